// File: rtl/router_fsm_ctrl.sv
// Packet sequencing controller for the router input datapath and output FIFOs.
// One-hot state register; every control output is a direct decode of it.
module router_fsm_ctrl #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [ADDR_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic [NUM_PORTS-1:0]  fifo_empty,
  input  logic [NUM_PORTS-1:0]  soft_reset,
  input  logic                  parity_done,
  input  logic                  low_pkt_valid,
  output logic [ADDR_WIDTH-1:0] sel_addr,
  output logic                  write_enb_reg,
  output logic                  detect_add,
  output logic                  lfd_state,
  output logic                  ld_state,
  output logic                  laf_state,
  output logic                  full_state,
  output logic                  rst_int_reg,
  output logic                  busy
);

  typedef enum logic [7:0] {
    DECODE_ADDRESS     = 8'b0000_0001,
    WAIT_TILL_EMPTY    = 8'b0000_0010,
    LOAD_FIRST_DATA    = 8'b0000_0100,
    LOAD_DATA          = 8'b0000_1000,
    FIFO_FULL_STATE    = 8'b0001_0000,
    LOAD_AFTER_FULL    = 8'b0010_0000,
    LOAD_PARITY        = 8'b0100_0000,
    CHECK_PARITY_ERROR = 8'b1000_0000
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_sel_addr;
  logic                  w_addr_ok;
  logic                  w_hdr_accept;
  logic                  w_soft_sel;
  logic                  w_empty_new;
  logic                  w_empty_sel;

  // Per-port flag lookup that stays in range even when the address field can
  // encode more values than there are ports.
  function automatic logic port_bit(input logic [NUM_PORTS-1:0]  i_vec,
                                    input logic [ADDR_WIDTH-1:0] i_idx);
    logic v_bit;
    v_bit = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      v_bit = v_bit | (i_vec[i] & (i_idx == ADDR_WIDTH'(i)));
    end
    return v_bit;
  endfunction

  assign w_addr_ok    = ({1'b0, data_in} < (ADDR_WIDTH+1)'(NUM_PORTS));
  assign w_hdr_accept = pkt_valid & w_addr_ok;
  assign w_soft_sel   = port_bit(soft_reset, r_sel_addr);
  assign w_empty_new  = port_bit(fifo_empty, data_in);
  assign w_empty_sel  = port_bit(fifo_empty, r_sel_addr);

  // State register and destination address latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= DECODE_ADDRESS;
      r_sel_addr <= {ADDR_WIDTH{1'b0}};
    end else begin
      r_state <= w_next_state;
      if ((r_state == DECODE_ADDRESS) && w_hdr_accept) begin
        r_sel_addr <= data_in;
      end else begin
        r_sel_addr <= r_sel_addr;
      end
    end
  end

  // Next-state logic; a timeout on the selected port abandons the packet.
  always_comb begin
    w_next_state = r_state;
    if ((r_state != DECODE_ADDRESS) && w_soft_sel) begin
      w_next_state = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS: begin
          if (w_hdr_accept) begin
            w_next_state = w_empty_new ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end else begin
            w_next_state = DECODE_ADDRESS;
          end
        end
        WAIT_TILL_EMPTY:  w_next_state = w_empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA:  w_next_state = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full) begin
            w_next_state = FIFO_FULL_STATE;
          end else if (!pkt_valid) begin
            w_next_state = LOAD_PARITY;
          end else begin
            w_next_state = LOAD_DATA;
          end
        end
        FIFO_FULL_STATE:  w_next_state = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (parity_done) begin
            w_next_state = DECODE_ADDRESS;
          end else if (low_pkt_valid) begin
            w_next_state = LOAD_PARITY;
          end else begin
            w_next_state = LOAD_DATA;
          end
        end
        LOAD_PARITY:        w_next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:            w_next_state = DECODE_ADDRESS;
      endcase
    end
  end

  assign sel_addr      = r_sel_addr;
  assign detect_add    = (r_state == DECODE_ADDRESS);
  assign lfd_state     = (r_state == LOAD_FIRST_DATA);
  assign ld_state      = (r_state == LOAD_DATA);
  assign laf_state     = (r_state == LOAD_AFTER_FULL);
  assign full_state    = (r_state == FIFO_FULL_STATE);
  assign rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
  assign write_enb_reg = lfd_state | ld_state | laf_state | (r_state == LOAD_PARITY);
  assign busy          = (r_state == WAIT_TILL_EMPTY) | lfd_state | full_state |
                         laf_state | (r_state == LOAD_PARITY) | rst_int_reg;

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Scoreboard bench for router_fsm_ctrl: expected output vectors are queued as
// stimulus is applied and compared once the clock edge has produced the result.
module tb_router_fsm_ctrl;
  localparam int NP = 3;
  localparam int AW = 2;
  localparam int S_DA = 0, S_WTE = 1, S_LFD = 2, S_LD = 3;
  localparam int S_FFS = 4, S_LAF = 5, S_LP = 6, S_CPE = 7;

  logic          clock, reset, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [AW-1:0] data_in;
  logic [NP-1:0] fifo_empty, soft_reset;
  logic [AW-1:0] sel_addr;
  logic          write_enb_reg, detect_add, lfd_state, ld_state;
  logic          laf_state, full_state, rst_int_reg, busy;
  logic [9:0]    w_obs;

  int         n_cmp;
  int         n_bad;
  string      q_tag[$];
  logic [9:0] q_exp[$];

  router_fsm_ctrl #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .sel_addr(sel_addr),
    .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  assign w_obs = {sel_addr, write_enb_reg, detect_add, lfd_state, ld_state,
                  laf_state, full_state, rst_int_reg, busy};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Output vector order: sel_addr[1:0], we, detect, lfd, ld, laf, full, rst_int, busy.
  function automatic logic [9:0] exp_out(input int st, input logic [1:0] sel);
    logic [7:0] f;
    case (st)
      S_DA:    f = 8'b0100_0000;
      S_WTE:   f = 8'b0000_0001;
      S_LFD:   f = 8'b1010_0001;
      S_LD:    f = 8'b1001_0000;
      S_FFS:   f = 8'b0000_0101;
      S_LAF:   f = 8'b1000_1001;
      S_LP:    f = 8'b1000_0001;
      S_CPE:   f = 8'b0000_0011;
      default: f = 8'b0000_0000;
    endcase
    return {sel, f};
  endfunction

  task automatic check_eq(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (sel,we,da,lfd,ld,laf,full,rst,busy)",
               tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input int st, input logic [1:0] sel);
    q_tag.push_back(tag);
    q_exp.push_back(exp_out(st, sel));
    @(posedge clock);
    #1;
    check_eq(q_tag.pop_front(), w_obs, q_exp.pop_front());
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
    #12;
    check_eq("reset", w_obs, exp_out(S_DA, 2'd0));
    reset = 1'b0;
    cyc("idle", S_DA, 2'd0);

    // Minimum packet to port 1 with three payload bytes.
    pkt_valid = 1'b1; data_in = 2'd1;
    cyc("t2_hdr", S_LFD, 2'd1);
    data_in = 2'd3;
    cyc("t2_lfd", S_LD, 2'd1);
    cyc("t2_ld1", S_LD, 2'd1);
    cyc("t2_ld2", S_LD, 2'd1);
    pkt_valid = 1'b0;
    cyc("t2_lp", S_LP, 2'd1);
    cyc("t2_cpe", S_CPE, 2'd1);
    cyc("t2_da", S_DA, 2'd1);

    // Out-of-range header and headers without pkt_valid are dropped.
    pkt_valid = 1'b1; data_in = 2'd3;
    cyc("t5_bad_addr", S_DA, 2'd1);
    cyc("t5_bad_addr2", S_DA, 2'd1);
    pkt_valid = 1'b0; data_in = 2'd2;
    cyc("t5_no_valid", S_DA, 2'd1);

    // Port 2 not empty for five cycles; other ports empty.
    fifo_empty = 3'b011; pkt_valid = 1'b1; data_in = 2'd2;
    cyc("t3_hdr", S_WTE, 2'd2);
    for (int i = 0; i < 4; i++) cyc("t3_wait", S_WTE, 2'd2);
    fifo_empty = 3'b111;
    cyc("t3_lfd", S_LFD, 2'd2);
    cyc("t3_ld", S_LD, 2'd2);
    pkt_valid = 1'b0;
    cyc("t3_lp", S_LP, 2'd2);
    cyc("t3_cpe", S_CPE, 2'd2);
    cyc("t3_da", S_DA, 2'd2);

    // Full stall, resume into LOAD_DATA.
    pkt_valid = 1'b1; data_in = 2'd0;
    cyc("t4a_hdr", S_LFD, 2'd0);
    cyc("t4a_ld", S_LD, 2'd0);
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) cyc("t4a_ffs", S_FFS, 2'd0);
    fifo_full = 1'b0;
    cyc("t4a_laf", S_LAF, 2'd0);
    cyc("t4a_ld2", S_LD, 2'd0);
    pkt_valid = 1'b0;
    cyc("t4a_lp", S_LP, 2'd0);
    cyc("t4a_cpe", S_CPE, 2'd0);
    cyc("t4a_da", S_DA, 2'd0);

    // Full and end-of-packet together, then resume into parity and CPE re-stall.
    pkt_valid = 1'b1; data_in = 2'd0;
    cyc("t4b_hdr", S_LFD, 2'd0);
    cyc("t4b_ld", S_LD, 2'd0);
    pkt_valid = 1'b0; fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) cyc("t4b_ffs", S_FFS, 2'd0);
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    cyc("t4b_laf", S_LAF, 2'd0);
    cyc("t4b_lp", S_LP, 2'd0);
    cyc("t4b_cpe", S_CPE, 2'd0);
    fifo_full = 1'b1;
    cyc("t4c_cpe_full", S_FFS, 2'd0);
    fifo_full = 1'b0;
    cyc("t4c_laf", S_LAF, 2'd0);
    parity_done = 1'b1;
    cyc("t4c_pdone", S_DA, 2'd0);
    parity_done = 1'b0; low_pkt_valid = 1'b0;

    // Soft resets: wrong port, selected port, and while decoding.
    pkt_valid = 1'b1; data_in = 2'd1;
    cyc("t6_hdr", S_LFD, 2'd1);
    cyc("t6_ld", S_LD, 2'd1);
    soft_reset = 3'b001;
    cyc("t6_other_port", S_LD, 2'd1);
    soft_reset = 3'b000;
    cyc("t6_ld2", S_LD, 2'd1);
    soft_reset = 3'b010;
    cyc("t6_sel_port", S_DA, 2'd1);
    data_in = 2'd2;
    cyc("t6_in_da", S_LFD, 2'd2);
    soft_reset = 3'b100;
    cyc("t6_lfd_srst", S_DA, 2'd2);
    soft_reset = 3'b000; pkt_valid = 1'b0;
    cyc("t6_idle", S_DA, 2'd2);

    // Asynchronous reset in the middle of LOAD_DATA.
    pkt_valid = 1'b1; data_in = 2'd2;
    cyc("t1_hdr", S_LFD, 2'd2);
    cyc("t1_ld", S_LD, 2'd2);
    #1 reset = 1'b1;
    #1 check_eq("t1_async_rst", w_obs, exp_out(S_DA, 2'd0));
    @(posedge clock);
    #1 check_eq("t1_rst_hold", w_obs, exp_out(S_DA, 2'd0));
    reset = 1'b0; pkt_valid = 1'b0;
    cyc("t1_after", S_DA, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
